// File: rtl/phv_merge.sv
// phv_merge: RMT stage writeback. Buffers each issued PHV during the ALU
// latency and substitutes the returned per-container results into it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   phv_in/_valid/_ready  original PHV, accepted when issued to the ALUs
//   alu_container_in      concatenated ALU results, ALU i at slice i
//   alu_container_valid   per-ALU result valid (mask)
//   phv_out/_valid/_ready merged PHV towards the next stage
//   err_orphan            sticky: result arrived with no PHV waiting for it
//   err_partial           sticky: result mask neither empty nor full
module phv_merge #(
    parameter int STAGE_ID   = 0,
    parameter int NUM_CONT   = 8,
    parameter int DATA_WIDTH = 48,
    parameter int META_WIDTH = 256,
    parameter int PHV_LEN    = NUM_CONT*DATA_WIDTH+META_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PHV_LEN-1:0]             phv_in,
    input  logic                           phv_in_valid,
    output logic                           phv_in_ready,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] alu_container_in,
    input  logic [NUM_CONT-1:0]            alu_container_valid,
    output logic [PHV_LEN-1:0]             phv_out,
    output logic                           phv_out_valid,
    input  logic                           phv_out_ready,
    output logic                           err_orphan,
    output logic                           err_partial
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = NUM_CONT*DATA_WIDTH;
    localparam int RW = NUM_CONT+CW;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    if (DEPTH < 4 || (DEPTH & (DEPTH-1)) != 0 || STAGE_ID < 0)
    begin : g_param_chk
        $error("phv_merge: DEPTH must be a power of two >= 4");
    end

    logic [PHV_LEN-1:0] phv_mem [DEPTH];
    logic [RW-1:0]      res_mem [DEPTH];

    logic [AW:0] pwr_q, pwr_d, prd_q, prd_d;
    logic [AW:0] rwr_q, rwr_d, rrd_q, rrd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [AW:0] pocc, rocc;

    logic [PHV_LEN-1:0] out_q, out_d;
    logic               vld_q, vld_d;
    logic               orph_q, orph_d;
    logic               part_q, part_d;

    logic               phv_acc, out_hs;
    logic               res_any, orphan, partial, res_wr, merge;
    logic [PHV_LEN-1:0] phv_head, merged;
    logic [RW-1:0]      res_head;

    // Occupancies from wide pointers; the extra MSB resolves full vs empty.
    assign pocc = pwr_q - prd_q;
    assign rocc = rwr_q - rrd_q;

    assign phv_in_ready = (cnt_q < DEPTH_V);
    assign phv_acc      = phv_in_valid & phv_in_ready;
    assign out_hs       = vld_q & phv_out_ready;

    // A result is orphaned when every buffered PHV already has its result.
    assign res_any = |alu_container_valid;
    assign orphan  = res_any & (rocc >= pocc);
    assign partial = res_any & ~(&alu_container_valid);
    assign res_wr  = res_any & ~orphan;

    assign merge = (pocc != '0) & (rocc != '0) & (~vld_q | phv_out_ready);

    assign phv_head = phv_mem[prd_q[AW-1:0]];
    assign res_head = res_mem[rrd_q[AW-1:0]];

    always_comb begin
        merged = phv_head;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (res_head[CW+i]) begin
                merged[META_WIDTH+i*DATA_WIDTH +: DATA_WIDTH] =
                    res_head[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        pwr_d  = phv_acc ? pwr_q + ONE_V : pwr_q;
        rwr_d  = res_wr  ? rwr_q + ONE_V : rwr_q;
        prd_d  = merge   ? prd_q + ONE_V : prd_q;
        rrd_d  = merge   ? rrd_q + ONE_V : rrd_q;
        cnt_d  = cnt_q;
        unique case ({phv_acc, out_hs})
            2'b10:   cnt_d = cnt_q + ONE_V;
            2'b01:   cnt_d = cnt_q - ONE_V;
            default: cnt_d = cnt_q;
        endcase
        out_d  = merge ? merged : out_q;
        vld_d  = merge ? 1'b1 : (out_hs ? 1'b0 : vld_q);
        orph_d = orph_q | orphan;
        part_d = part_q | partial;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_q  <= '0;
            prd_q  <= '0;
            rwr_q  <= '0;
            rrd_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            orph_q <= 1'b0;
            part_q <= 1'b0;
        end else begin
            pwr_q  <= pwr_d;
            prd_q  <= prd_d;
            rwr_q  <= rwr_d;
            rrd_q  <= rrd_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            orph_q <= orph_d;
            part_q <= part_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (phv_acc) phv_mem[pwr_q[AW-1:0]] <= phv_in;
        if (res_wr)  res_mem[rwr_q[AW-1:0]] <= {alu_container_valid, alu_container_in};
    end

    assign phv_out       = out_q;
    assign phv_out_valid = vld_q;
    assign err_orphan    = orph_q;
    assign err_partial   = part_q;

endmodule
